cache_4way_l2: RTL and testbench
================================

Name: cache_4way_l2

Overview:
Read-only, 4-way set-associative L2 cache model with tree pseudo-LRU replacement and an internal, deterministic backing store.
- Every read request is looked up and reported as hit or miss with one-cycle latency.
- A miss allocates the block in the same cycle.
- Sits below L1 in the cache-simulator hierarchy, where it is used for hit/miss and replacement studies.

Parameters:
ADDR_WIDTH, 11, byte-address width
DATA_WIDTH, 32, word width returned on read_data
NUM_WAYS, 4, associativity; fixed at 4 because the PLRU tree is 3 bits
BLOCK_BYTES, 32, block size (8 words); offset = addr[4:0]
NUM_SETS, 2, set count; index = addr[5], tag = addr[10:6] (5 bits)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous, active-high reset
read  input  1  read request, sampled each rising edge
addr  input  ADDR_WIDTH  byte address; word select = addr[4:2]
hit  output  1  registered result of the last request: 1 = hit, 0 = miss
read_data  output  DATA_WIDTH  registered word for the last request

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset, synchronous on a rising edge with rst=1:
  - all valid bits cleared, all PLRU bits cleared, tags don't-care;
  - hit=0, read_data=0.
  - rst has priority over read.
- Backing store: word value at byte address A = 32'hCAFE_0000 | {A[10:2],2'b00}, zero-extended to DATA_WIDTH. It is combinational, with no latency.
- Stored data: each way holds 8 words. A refill loads all 8 words of the block.
- Request: at a rising edge with read=1 and rst=0, lookup of set index=addr[5], compared against the tags of all 4 ways.
- Hit, when some way is valid and its tag matches:
  - hit<=1;
  - read_data<=stored word addr[4:2];
  - PLRU updated for that way.
- Miss:
  - victim = lowest-index invalid way, otherwise the PLRU victim;
  - victim filled (valid=1, tag and data written) in the same edge;
  - hit<=0; read_data<=backing word for addr;
  - PLRU updated for the victim way.
- Latency is 1 cycle: outputs become valid after the rising edge that sampled read=1. No stall, no busy signal; back-to-back reads are accepted every cycle.
- read=0: hit, read_data, tags and PLRU all hold their values.
- PLRU, 3 bits per set:
  - b0 = root: 0 selects ways 0/1, 1 selects ways 2/3;
  - b1 = left pair: 0 selects way0, 1 selects way1;
  - b2 = right pair: 0 selects way2, 1 selects way3.
- PLRU update on access (points away from the accessed way):
  - way0: b0=1, b1=1
  - way1: b0=1, b1=0
  - way2: b0=0, b2=1
  - way3: b0=0, b2=0
- Address bits [1:0] are ignored.
- Read of the same address in consecutive cycles: the second read hits and returns the value just filled.
- rst asserted mid-stream: the cache is flushed at that edge and the next read misses.

Decomposition:
- Package cache_4way_l2_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH, OFFSET_BITS=5, INDEX_BITS=1, TAG_BITS=5, NUM_WAYS;
  - a plru_t 3-bit typedef;
  - the backing-word function.
- Sub-module plru_tree4 is combinational. Inputs: 3-bit state and accessed way. Outputs: next state and 2-bit victim.

Test Plan:
1. Reset, then read addresses 0x000,0x020,…,0x0E0 (i*32, i=0..7) → each hit=0, read_data=0xCAFE0000|addr (e.g. 0x0E0 → 0xCAFE00E0).
2. Re-read the same 8 addresses in order → all hit=1, same data as step 1.
3. Read 0x100, 0x120, 0x140, 0x160 → all hit=0. Victims: 0x100 evicts 0x000 (set0 way0), 0x120 evicts 0x020, 0x140 evicts 0x080 (way2), 0x160 evicts 0x0A0.
4. Read 0x000 → hit=0, data 0xCAFE0000, evicts 0x040 (way1). Then read 0x0C0 → hit=1 and read 0x040 → hit=0.
5. Read 0x024 after 0x020 is resident → hit=1, read_data=0xCAFE0024 (word select). Hold read=0 for 3 cycles → outputs unchanged.
6. Assert rst for one edge with the cache full → hit=0, read_data=0. The next read of 0x0C0 → hit=0.

Source files
------------

// File: rtl/cache_4way_l2_pkg.sv
// Shared geometry, PLRU state type and the deterministic backing-store
// function for the 4-way L2 cache model.
package cache_4way_l2_pkg;

  localparam int ADDR_WIDTH      = 11;
  localparam int DATA_WIDTH      = 32;
  localparam int OFFSET_BITS     = 5;
  localparam int INDEX_BITS      = 1;
  localparam int TAG_BITS        = 5;
  localparam int NUM_WAYS        = 4;
  localparam int NUM_SETS        = 2;
  localparam int WORDS_PER_BLOCK = 8;

  typedef logic [2:0] plru_t;

  // Word at byte address {word_addr, 2'b00}; zero-extended into DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] backing_word(input logic [ADDR_WIDTH-3:0] word_addr);
    return 32'hCAFE_0000 | {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/cache_4way_l2_plru_tree4.sv
// Combinational 3-bit tree pseudo-LRU: victim from the current state and
// next state after touching a given way.
module plru_tree4
  import cache_4way_l2_pkg::*;
(
  input  plru_t      state_i,
  input  logic [1:0] way_i,
  output plru_t      next_o,
  output logic [1:0] victim_o
);

  always_comb begin
    next_o = state_i;
    // Each update points the tree bits away from the accessed way.
    case (way_i)
      2'd0:    begin next_o[0] = 1'b1; next_o[1] = 1'b1; end
      2'd1:    begin next_o[0] = 1'b1; next_o[1] = 1'b0; end
      2'd2:    begin next_o[0] = 1'b0; next_o[2] = 1'b1; end
      default: begin next_o[0] = 1'b0; next_o[2] = 1'b0; end
    endcase
  end

  always_comb begin
    victim_o = 2'd0;
    if (state_i[0]) victim_o = state_i[2] ? 2'd3 : 2'd2;
    else            victim_o = state_i[1] ? 2'd1 : 2'd0;
  end

endmodule

// File: rtl/cache_4way_l2.sv
// Read-only 4-way set-associative L2 model: one-cycle registered hit/miss,
// allocate-on-miss from an internal backing store, tree PLRU replacement.
module cache_4way_l2
  import cache_4way_l2_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] read_data
);

  // Protocol: a request is taken on every rising edge with read=1 (no
  // backpressure); hit/read_data describe it from the following edge on.

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [TAG_BITS-1:0]   tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS][WORDS_PER_BLOCK];
  plru_t                 plru_q  [NUM_SETS];
  logic                  hit_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] idx;
  logic [2:0]            word;
  logic [NUM_WAYS-1:0]   hit_vec;
  logic [1:0]            hit_way;
  logic [1:0]            fill_way;
  logic [1:0]            access_way;
  logic [1:0]            plru_victim;
  logic                  is_hit;
  plru_t                 plru_d;
  logic                  unused_byte_bits;

  assign tag              = addr[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
  assign idx              = addr[OFFSET_BITS +: INDEX_BITS];
  assign word             = addr[4:2];
  assign unused_byte_bits = ^addr[1:0];

  always_comb begin
    hit_vec  = '0;
    hit_way  = 2'd0;
    fill_way = plru_victim;
    for (int w = 0; w < NUM_WAYS; w++)
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
    // Descending scan so the lowest-index match / invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])         hit_way  = 2'(w);
      if (!valid_q[idx][w])   fill_way = 2'(w);
    end
    is_hit     = |hit_vec;
    access_way = is_hit ? hit_way : fill_way;
  end

  plru_tree4 u_plru (
    .state_i  (plru_q[idx]),
    .way_i    (access_way),
    .next_o   (plru_d),
    .victim_o (plru_victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else if (read) begin
      plru_q[idx] <= plru_d;
      if (is_hit) begin
        hit_q   <= 1'b1;
        rdata_q <= data_q[idx][hit_way][word];
      end else begin
        hit_q                   <= 1'b0;
        rdata_q                 <= backing_word(addr[ADDR_WIDTH-1:2]);
        valid_q[idx][fill_way]  <= 1'b1;
        tag_q[idx][fill_way]    <= tag;
        for (int k = 0; k < WORDS_PER_BLOCK; k++)
          data_q[idx][fill_way][k] <= backing_word({tag, idx, 3'(k)});
      end
    end
  end

  assign hit       = hit_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_cache_4way_l2.sv
// Directed bench for cache_4way_l2: cold fills, re-hits, PLRU evictions,
// word select, idle hold and mid-stream reset flush.
module tb_cache_4way_l2;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [10:0] addr;
  logic        hit;
  logic [31:0] read_data;

  int n_checks = 0;
  int n_fail   = 0;

  cache_4way_l2 dut (
    .clk       (clk),
    .rst       (rst),
    .read      (read),
    .addr      (addr),
    .hit       (hit),
    .read_data (read_data)
  );

  always #5 clk = ~clk;

  task automatic drive_read(input logic [10:0] a);
    @(negedge clk);
    rst  = 1'b0;
    read = 1'b1;
    addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    read = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; read = 1'b0; addr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (hit !== 1'b0) begin
      n_fail++; $display("FAIL reset_hit: got %b expected 0", hit);
    end
    n_checks++;
    if (read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00000000", read_data);
    end
  endtask

  task automatic test_cold_fill();
    for (int i = 0; i < 8; i++) begin
      drive_read(11'(i * 32));
      n_checks++;
      if (hit !== 1'b0) begin
        n_fail++; $display("FAIL cold_hit[%0d]: got %b expected 0", i, hit);
      end
      n_checks++;
      if (read_data !== (32'hCAFE_0000 + 32'(i * 32))) begin
        n_fail++; $display("FAIL cold_data[%0d]: got %h expected %h", i, read_data, 32'hCAFE_0000 + 32'(i * 32));
      end
    end
  endtask

  task automatic test_rehit();
    for (int i = 0; i < 8; i++) begin
      drive_read(11'(i * 32));
      n_checks++;
      if (hit !== 1'b1) begin
        n_fail++; $display("FAIL rehit_hit[%0d]: got %b expected 1", i, hit);
      end
      n_checks++;
      if (read_data !== (32'hCAFE_0000 + 32'(i * 32))) begin
        n_fail++; $display("FAIL rehit_data[%0d]: got %h expected %h", i, read_data, 32'hCAFE_0000 + 32'(i * 32));
      end
    end
  endtask

  task automatic test_evict();
    logic [10:0] a_tab [4] = '{11'h100, 11'h120, 11'h140, 11'h160};
    logic [31:0] d_tab [4] = '{32'hCAFE_0100, 32'hCAFE_0120, 32'hCAFE_0140, 32'hCAFE_0160};
    for (int i = 0; i < 4; i++) begin
      drive_read(a_tab[i]);
      n_checks++;
      if (hit !== 1'b0) begin
        n_fail++; $display("FAIL evict_hit[%h]: got %b expected 0", a_tab[i], hit);
      end
      n_checks++;
      if (read_data !== d_tab[i]) begin
        n_fail++; $display("FAIL evict_data[%h]: got %h expected %h", a_tab[i], read_data, d_tab[i]);
      end
    end
  endtask

  task automatic test_plru_victim();
    // 0x000 was evicted by 0x100 and now replaces way1 (0x040); 0x0C0 stays.
    logic [10:0] a_tab [3] = '{11'h000, 11'h0C0, 11'h040};
    logic        h_tab [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] d_tab [3] = '{32'hCAFE_0000, 32'hCAFE_00C0, 32'hCAFE_0040};
    for (int i = 0; i < 3; i++) begin
      drive_read(a_tab[i]);
      n_checks++;
      if (hit !== h_tab[i]) begin
        n_fail++; $display("FAIL plru_hit[%h]: got %b expected %b", a_tab[i], hit, h_tab[i]);
      end
      n_checks++;
      if (read_data !== d_tab[i]) begin
        n_fail++; $display("FAIL plru_data[%h]: got %h expected %h", a_tab[i], read_data, d_tab[i]);
      end
    end
  endtask

  task automatic test_word_select_hold();
    drive_read(11'h020);
    n_checks++;
    if (hit !== 1'b0 || read_data !== 32'hCAFE_0020) begin
      n_fail++; $display("FAIL refill_020: got hit=%b data=%h expected hit=0 data=cafe0020", hit, read_data);
    end
    drive_read(11'h024);
    n_checks++;
    if (hit !== 1'b1 || read_data !== 32'hCAFE_0024) begin
      n_fail++; $display("FAIL word_sel_024: got hit=%b data=%h expected hit=1 data=cafe0024", hit, read_data);
    end
    drive_read(11'h03F);
    n_checks++;
    if (hit !== 1'b1 || read_data !== 32'hCAFE_003C) begin
      n_fail++; $display("FAIL word_sel_03f: got hit=%b data=%h expected hit=1 data=cafe003c", hit, read_data);
    end
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      n_checks++;
      if (hit !== 1'b1 || read_data !== 32'hCAFE_003C) begin
        n_fail++; $display("FAIL idle_hold[%0d]: got hit=%b data=%h expected hit=1 data=cafe003c", i, hit, read_data);
      end
    end
  endtask

  task automatic test_reset_flush();
    // rst wins over a simultaneous read.
    @(negedge clk);
    rst = 1'b1; read = 1'b1; addr = 11'h0C0;
    @(posedge clk);
    #1;
    n_checks++;
    if (hit !== 1'b0 || read_data !== 32'h0) begin
      n_fail++; $display("FAIL flush_out: got hit=%b data=%h expected hit=0 data=00000000", hit, read_data);
    end
    drive_read(11'h0C0);
    n_checks++;
    if (hit !== 1'b0 || read_data !== 32'hCAFE_00C0) begin
      n_fail++; $display("FAIL flush_miss: got hit=%b data=%h expected hit=0 data=cafe00c0", hit, read_data);
    end
    drive_read(11'h0C8);
    n_checks++;
    if (hit !== 1'b1 || read_data !== 32'hCAFE_00C8) begin
      n_fail++; $display("FAIL back_to_back: got hit=%b data=%h expected hit=1 data=cafe00c8", hit, read_data);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_rehit();
    test_evict();
    test_plru_victim();
    test_word_select_hold();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
